alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_exec_unit.sv | 101 ++++++++++
 tb/tb_alu_exec_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants used by the control decoder and
// the execution unit, plus the execution unit's state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result bundle for the ALU execution unit. The master issues
// operations and consumes results; the slave is the execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] data;
  logic             zero;

  modport master (
    output valid, alu_ctrl, data1, data2, res_ready,
    input  ready, res_valid, data, zero
  );

  modport slave (
    input  valid, alu_ctrl, data1, data2, res_ready,
    output ready, res_valid, data, zero
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier. A start pulse loads the operands and clears
// the accumulator; one multiplier bit is consumed per clock. done_o flags the
// edge on which the WIDTH-th iteration completes, with product_o already
// holding the final (wrapped) product, so the caller can capture it directly.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_d;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_d;

  // Operand load on start, then one shift-add step per clock until the last bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops and a fixed-latency
// iterative multiply, behind a valid/ready request and a valid/ready result.
//
//   state   | meaning
//   IDLE    | ready for a request; data_o holds the previous result
//   MUL     | multiplier iterating, requests ignored
//   DONE    | result presented, held until the consumer accepts it
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] alu_res;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (mul_start),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle operations; undefined codes (including mul here) yield zero.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      default: alu_res = '0;
    endcase
  end

  // Next-state and result capture; DONE always returns to IDLE before a new request.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            state_d = ST_DONE;
            data_d  = alu_res;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
          data_d  = mul_product;
        end
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign data_o  = data_q;
  assign zero_o  = (data_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes model results into a
// queue, a negedge monitor pops and compares on every accepted result.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (bus.valid),
    .ready_o   (bus.ready),
    .ALUCtrl_i (bus.alu_ctrl),
    .data1_i   (bus.data1),
    .data2_i   (bus.data2),
    .valid_o   (bus.res_valid),
    .ready_i   (bus.res_ready),
    .data_o    (bus.data),
    .zero_o    (bus.zero)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b101:  return p[WIDTH-1:0];
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request; returns just after the transfer edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit push, input bit rand_bp);
    int n = 0;
    while (!bus.ready && n < 300) begin
      if (rand_bp) bus.res_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= 300) chk("issue_timeout", 64'(n), 64'(0));
    bus.valid = 1'b1;
    bus.alu_ctrl = op;
    bus.data1 = a;
    bus.data2 = b;
    if (push) exp_q.push_back(model(op, a, b));
    tick();
    bus.valid = 1'b0;
    bus.alu_ctrl = 3'($urandom);
    bus.data1 = $urandom;
    bus.data2 = $urandom;
  endtask

  task automatic drain;
    int n = 0;
    bus.res_ready = 1'b1;
    while (!bus.ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(n), 64'(0));
  endtask

  // Scoreboard monitor: compare whenever a result is accepted.
  always @(negedge clk_i) begin
    if (rst_n_i && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h with empty scoreboard at %0t", bus.data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("result_data", 64'(bus.data), 64'(e));
        chk("result_zero", 64'(bus.zero), 64'(e == '0));
      end
    end
  end

  initial begin
    int lat;
    bus.valid = 1'b0;
    bus.alu_ctrl = 3'b000;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.res_ready = 1'b1;
    #12;
    chk("rst_valid_o", 64'(bus.res_valid), 64'(0));
    chk("rst_data_o", 64'(bus.data), 64'(0));
    chk("rst_zero_o", 64'(bus.zero), 64'(1));
    chk("rst_ready_o", 64'(bus.ready), 64'(1));
    rst_n_i = 1'b1;
    tick();

    // add 7 + 5: result right after the transfer edge, ready_o back next cycle
    issue(3'b010, 7, 5, 1, 0);
    chk("add_valid_lat", 64'(bus.res_valid), 64'(1));
    chk("add_data", 64'(bus.data), 64'(12));
    chk("add_ready_busy", 64'(bus.ready), 64'(0));
    tick();
    chk("add_ready_back", 64'(bus.ready), 64'(1));
    chk("add_valid_drop", 64'(bus.res_valid), 64'(0));
    chk("add_data_held", 64'(bus.data), 64'(12));

    issue(3'b110, 5, 5, 1, 0);
    chk("sub_zero", 64'(bus.zero), 64'(1));
    drain();
    issue(3'b110, 0, 1, 1, 0);
    chk("sub_wrap", 64'(bus.data), 64'(32'hFFFF_FFFF));
    drain();
    issue(3'b000, 32'hF0F0, 32'h0FF0, 1, 0);
    drain();
    issue(3'b001, 32'hF000, 32'h000F, 1, 0);
    drain();
    issue(3'b011, 32'h1234, 32'h5678, 1, 0);
    chk("undef_zero", 64'(bus.zero), 64'(1));
    drain();

    // mul: fixed latency, requests during MUL ignored
    issue(3'b101, 32'h0001_0001, 32'h0001_0001, 1, 0);
    lat = 0;
    bus.valid = 1'b1;
    bus.alu_ctrl = 3'b010;
    for (int i = 0; i < 5; i++) begin
      chk("mul_ready_low", 64'(bus.ready), 64'(0));
      chk("mul_valid_low", 64'(bus.res_valid), 64'(0));
      tick();
      lat++;
    end
    bus.valid = 1'b0;
    while (!bus.res_valid && lat < 100) begin
      chk("mul_ready_low", 64'(bus.ready), 64'(0));
      tick();
      lat++;
    end
    chk("mul_latency", 64'(lat), 64'(WIDTH));
    chk("mul_data", 64'(bus.data), 64'(32'h0002_0001));
    drain();
    issue(3'b101, 0, 32'hDEAD_BEEF, 1, 0);
    lat = 0;
    while (!bus.res_valid && lat < 100) begin tick(); lat++; end
    chk("mul_zero_latency", 64'(lat), 64'(WIDTH));
    drain();

    // backpressure: result held for 5 cycles
    bus.res_ready = 1'b0;
    issue(3'b001, 32'h00A0, 32'h0005, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.res_valid), 64'(1));
      chk("bp_data", 64'(bus.data), 64'(32'h00A5));
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 64'(bus.ready), 64'(1));
    chk("bp_idle_valid", 64'(bus.res_valid), 64'(0));

    // reset 10 cycles into a mul abandons it
    issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_mid_data", 64'(bus.data), 64'(0));
    chk("rst_mid_ready", 64'(bus.ready), 64'(1));
    chk("rst_mid_zero", 64'(bus.zero), 64'(1));
    tick();
    rst_n_i = 1'b1;
    tick();
    issue(3'b010, 2, 3, 1, 0);
    chk("post_rst_valid", 64'(bus.res_valid), 64'(1));
    chk("post_rst_data", 64'(bus.data), 64'(5));
    drain();

    // randomized traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      if ($urandom_range(0, 3) == 0) op = 3'b101;
      issue(op, $urandom, $urandom, 1, 1);
    end
    drain();
    tick();
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
